// File: rtl/shift_request_sequencer.sv
// Sequential front-end for an 8-bit combinational barrel shifter: splits a 0..31 left shift
// into passes of at most 7, feeding the shifter output back as the next pass input.
module shift_request_sequencer #(
  parameter int DATA_W   = 8,
  parameter int AMT_W    = 5,
  parameter int MAX_STEP = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  output logic [DATA_W-1:0] sh_x,
  output logic [2:0]        sh_y,
  input  logic [DATA_W-1:0] sh_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] acc_q;
  logic [AMT_W-1:0]  rem_q;
  logic [DATA_W-1:0] outData_q;
  logic              outValid_q;

  logic [2:0]        step;
  logic              lastPass;

  // Each pass shifts by the largest amount the shifter can do; the final pass takes the remainder.
  always_comb begin
    lastPass = (rem_q <= AMT_W'(MAX_STEP));
    step     = lastPass ? rem_q[2:0] : 3'(MAX_STEP);
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sh_x      = (state_q == RUN) ? acc_q : '0;
  assign sh_y      = (state_q == RUN) ? step  : 3'd0;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q   <= in_data;
            rem_q   <= in_amt;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= sh_z;
          rem_q <= rem_q - AMT_W'(step);
          if (lastPass) begin
            outData_q  <= sh_z;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          // Result stays put until the consumer takes it; no new request meanwhile.
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
